// File: rtl/dmem_responder.sv
// Handshaked, wait-stated, byte-lane word memory serving one request at a time.
// Optional DMEM_RESPONDER_ERR_EN flags misaligned/out-of-range requests with rsp_err.
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | counting down wait cycles, access on cnt==0
//   RESP  | response held until rsp_ready
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          we_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          err_q;
  logic          req_err;
  logic          do_access;
  logic [31:0]   mem [DEPTH];

`ifdef DMEM_RESPONDER_ERR_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
`else
  logic unused_addr;
  assign req_err     = 1'b0;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign do_access = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      err_q     <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= req_err;
            cnt     <= 4'(LATENCY);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_rdata <= (we_q || err_q) ? 32'h0 : mem[idx_q];
            rsp_err   <= err_q;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is deliberately unreset; a reset during WAIT leaves state IDLE so no write lands.
  always_ff @(posedge clk) begin
    if (do_access && we_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (DEPTH=64, LATENCY=2, error feature off).
module tb_dmem_responder;
  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [DEPTH];
  logic [32:0] exp_q [$];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int stall, input string name);
    int          n;
    int          idx;
    logic [32:0] exp;
    idx = int'((addr >> 2) % DEPTH);
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
      exp_q.push_back({1'b0, 32'h0});
    end else begin
      exp_q.push_back({1'b0, model[idx]});
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_before: req_ready=%b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    exp = exp_q.pop_front();
    vectors++;
    if (n != LATENCY + 1) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles want %0d", name, n, LATENCY + 1);
      if (rsp_valid !== 1'b1) return;
    end
    vectors++;
    if (rsp_rdata !== exp[31:0] || rsp_err !== exp[32]) begin
      miscompares++;
      $display("FAIL %s data: rdata=%h err=%b want rdata=%h err=%b",
               name, rsp_rdata, rsp_err, exp[31:0], exp[32]);
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp[31:0] || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s stall%0d: valid=%b rdata=%h ready=%b want 1 %h 0",
                 name, s, rsp_valid, rsp_rdata, req_ready, exp[31:0]);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s release: valid=%b ready=%b want 0 1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, "init_store");
    txn(1'b0, 32'h0, 32'h0, 4'hF, 0, "first_load");
  endtask

  task automatic test_byte_lanes();
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, "st_full");
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, "ld_full");
    txn(1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0, "st_lane1");
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, "ld_lane1");
    txn(1'b1, 32'h10, 32'h12345678, 4'b0000, 0, "st_none");
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, "ld_none");
    txn(1'b1, 32'h14, 32'hA1B2C3D4, 4'b1001, 0, "st_lanes03");
  endtask

  task automatic test_backpressure();
    txn(1'b0, 32'h10, 32'h0, 4'hF, 5, "ld_stall");
  endtask

  task automatic test_reset_abort();
    txn(1'b1, 32'h20, 32'h11111111, 4'hF, 0, "st_20");
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, "ld_20");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_in_wait: ready=%b valid=%b want 0 0", req_ready, rsp_valid);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, "ld_20_after_abort");
  endtask

  task automatic test_wrap();
    txn(1'b1, 32'h100, 32'h5A5A5A5A, 4'hF, 0, "st_wrap");
    txn(1'b0, 32'h000, 32'h0, 4'hF, 0, "ld_wrap");
    txn(1'b0, 32'h003, 32'h0, 4'hF, 0, "ld_lowbits");
    txn(1'b0, 32'hFFFF_FF10, 32'h0, 4'hF, 0, "ld_highbits");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 8; i++)
      txn(1'b1, 32'h40 + 32'(4 * i), $urandom, 4'hF, 0, "b2b_fill");
    for (int i = 0; i < 24; i++) begin
      a = 32'h40 + 32'(4 * $urandom_range(0, 7));
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2), "b2b_mix");
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_backpressure();
    test_reset_abort();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the processor's load/store interface.
- Replaces the zero-latency combinational dmem with a handshaked, wait-stated, byte-lane word memory, so multicycle and pipelined cores can be tested against realistic memory timing.
- Serves one outstanding request at a time: accepts a request, waits LATENCY cycles, performs the access, then holds the response until it is consumed.

Parameters:
- DEPTH, 64, number of 32-bit words; power of 2, range 4..1024.
- LATENCY, 2, extra wait cycles between accept and access; range 0..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, little-endian byte lanes.
- req_be  in  4  byte enables; bit i enables byte lane [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores.
- rsp_err  out  1  error response (see Optional Feature).

Behaviour:
- States: IDLE, WAIT, RESP. A 4-bit counter cnt serves WAIT.
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array is not reset; its contents are undefined until written.
  - An in-flight transaction is aborted. A store not yet performed is dropped.
- Outputs are decoded from registered state only:
  - req_ready=1 iff state==IDLE; this includes while reset is asserted.
  - rsp_valid=1 iff state==RESP.
  - No combinational path from any input to any output.
- IDLE:
  - On the edge where req_valid&req_ready=1: latch we/addr/wdata/be, load cnt=LATENCY, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt!=0: decrement cnt.
  - If cnt==0: perform the access at word index addr[log2(DEPTH)+1:2], then go to RESP.
  - Load: rsp_rdata <= mem[index].
  - Store: write only the lanes enabled by be; rsp_rdata <= 0. be=4'b0000 writes nothing and still responds.
- Latency: rsp_valid rises LATENCY+1 cycles after the accept edge.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On the handshake edge go to IDLE.
  - No same-cycle re-accept. Minimum cycles per transaction = LATENCY+3.
- Requests are ignored outside IDLE. The requester must hold the request until req_ready=1.
- Address handling (feature off):
  - addr[1:0] are ignored.
  - Index bits above log2(DEPTH)+1 are ignored, so addresses wrap modulo DEPTH*4.
- A load following a store to the same word returns the stored data, since accesses are strictly serialized.

Optional Feature:
- Macro: DMEM_RESPONDER_ERR_EN.
- Defined: a request is in error if addr[1:0]!=0 or addr >= DEPTH*4. For an error request:
  - No memory write occurs.
  - rsp_rdata=0 and rsp_err=1.
  - Latency and handshake are identical to a normal request.
- Not defined: rsp_err is tied to 0, and aliasing/ignoring follows the address-handling rules above.

Test Plan:
- Reset release with LATENCY=2: req_ready=1, rsp_valid=0, rsp_rdata=0 -> a load accepted at edge k gives rsp_valid=1 from after edge k+3.
- Store addr=0x10, wdata=0xDEADBEEF, be=1111, then load 0x10 -> rsp_rdata=0xDEADBEEF. Then store be=0010, wdata=0x0000AA00, then load -> 0xDEADAAEF.
- Load response with rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata stable; req_ready=0 throughout. rsp_ready=1 -> IDLE next cycle.
- Reset pulsed low during WAIT of a store to 0x20 (which previously held 0x11111111) -> outputs return to reset values immediately; a later load of 0x20 returns 0x11111111.
- DEPTH=64, feature off: store 0x5A5A5A5A to addr 0x100, then load 0x000 -> 0x5A5A5A5A (wrap).
- DEPTH=64, feature on: store to addr 0x102 or 0x100 -> rsp_err=1, rsp_rdata=0, memory unchanged.
